// File: rtl/cp0_intc.sv
// CP0 interrupt/exception controller: Status, Cause and EPC, irq synchronisers,
// level/edge interrupt pending logic, event arbitration and an IE nesting stack.
module cp0_intc #(
  parameter int              NIRQ        = 6,
  parameter logic [NIRQ-1:0] EDGE_MASK   = '0,
  parameter int              SYNC_STG    = 2,
  parameter int              NEST_DEPTH  = 4,
  parameter logic [31:0]     EXC_BASE    = 32'h0000_0008,
  parameter bit              VECTORED    = 1'b0,
  parameter logic [31:0]     VEC_SPACING = 32'h20
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            inst_valid,
  input  logic [31:0]     pc,
  input  logic [31:0]     npc,
  input  logic            exc_ri,
  input  logic            exc_sys,
  input  logic            exc_ov,
  input  logic            eret,
  input  logic            mtc0,
  input  logic            mfc0,
  input  logic [4:0]      c0_sel,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [1:0]      selpc,
  output logic [31:0]     target,
  output logic            exc_take,
  output logic            inta,
  output logic            kill,
  output logic            nest_ovf
);

  localparam int              LW      = $clog2(NEST_DEPTH + 1);
  localparam logic [LW-1:0]   LVL_MAX = LW'(NEST_DEPTH);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SHADOW = 1'b1;

  localparam logic [4:0] SEL_STATUS = 5'd12;
  localparam logic [4:0] SEL_CAUSE  = 5'd13;
  localparam logic [4:0] SEL_EPC    = 5'd14;

  localparam logic [4:0] CODE_INT = 5'd0;
  localparam logic [4:0] CODE_SYS = 5'd8;
  localparam logic [4:0] CODE_RI  = 5'd10;
  localparam logic [4:0] CODE_OV  = 5'd12;

  logic [SYNC_STG-1:0][NIRQ-1:0] sync_q;
  logic [NIRQ-1:0]       synced, synced_d, edge_ip, ip, pending, edge_clr, im;
  logic [NEST_DEPTH-1:0] ie_stack;
  logic [4:0]            exc_code, entry_code;
  logic [31:0]           epc, win_idx, status_rd, cause_rd;
  logic [LW-1:0]         level;
  logic [0:0]            state;
  logic                  exc_any, sync_exc, int_take, eret_take, mtc0_take, entry, found;

  assign synced  = sync_q[SYNC_STG-1];
  assign ip      = (synced & ~EDGE_MASK) | (edge_ip & EDGE_MASK);
  assign pending = ip & im;

  // Event qualification; exceptions outrank eret, which outranks interrupts
  assign exc_any   = exc_ri | exc_sys | exc_ov;
  assign sync_exc  = !reset && inst_valid && exc_any;
  assign eret_take = !reset && inst_valid && !exc_any && eret;
  assign mtc0_take = !reset && inst_valid && !exc_any && !eret && mtc0;
  assign int_take  = !reset && inst_valid && !exc_any && !eret && !mtc0 &&
                     (state == ST_RUN) && ie_stack[0] && (|pending);
  assign entry     = sync_exc || int_take;

  // Lowest-numbered pending, enabled line wins
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (pending[i] && !found) begin
        win_idx = i;
        found   = 1'b1;
      end
    end
  end

  // ExcCode recorded on entry
  always_comb begin
    if (exc_ri)       entry_code = CODE_RI;
    else if (exc_sys) entry_code = CODE_SYS;
    else if (exc_ov)  entry_code = CODE_OV;
    else              entry_code = CODE_INT;
  end

  // PC override and entry flags
  always_comb begin
    exc_take = entry;
    inta     = int_take;
    kill     = sync_exc;
    selpc    = 2'd0;
    target   = '0;
    if (entry) begin
      selpc  = 2'd2;
      target = EXC_BASE;
      if (int_take && VECTORED)
        target = EXC_BASE + (win_idx + 32'd1) * VEC_SPACING;
    end else if (eret_take) begin
      selpc = 2'd1;
    end
  end

  // mfc0 read mux
  always_comb begin
    status_rd                   = '0;
    status_rd[8 +: NIRQ]        = im;
    status_rd[NEST_DEPTH-1:0]   = ie_stack;
    cause_rd                    = '0;
    cause_rd[8 +: NIRQ]         = ip;
    cause_rd[6:2]               = exc_code;
    rdata                       = '0;
    if (mfc0) begin
      case (c0_sel)
        SEL_STATUS: rdata = status_rd;
        SEL_CAUSE:  rdata = cause_rd;
        SEL_EPC:    rdata = epc;
        default:    rdata = '0;
      endcase
    end
  end

  // irq synchroniser chain plus one delayed copy for rising-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= '0;
      synced_d <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int unsigned s = 1; s < SYNC_STG; s++) sync_q[s] <= sync_q[s-1];
      synced_d <= synced;
    end
  end

  // Edge-line clear sources: mtc0 Cause with a 0 bit, or entry on that line
  always_comb begin
    edge_clr = '0;
    if (mtc0_take && c0_sel == SEL_CAUSE) edge_clr = ~wdata[8 +: NIRQ];
    if (int_take) edge_clr = edge_clr | (NIRQ'(1) << win_idx);
  end

  // Latched edge pending bits; a new rising edge wins over a clear
  always_ff @(posedge clock) begin
    if (reset) edge_ip <= '0;
    else       edge_ip <= ((edge_ip & ~edge_clr) | (synced & ~synced_d)) & EDGE_MASK;
  end

  // Architectural CP0 state and the RUN/SHADOW sequencer, advanced per retired instruction
  always_ff @(posedge clock) begin
    if (reset) begin
      ie_stack <= '0;
      im       <= '0;
      exc_code <= '0;
      epc      <= '0;
      level    <= '0;
      nest_ovf <= 1'b0;
      state    <= ST_RUN;
    end else if (inst_valid) begin
      if (entry) begin
        epc      <= sync_exc ? pc : npc;
        exc_code <= entry_code;
        ie_stack <= ie_stack << 1;
        if (level == LVL_MAX) nest_ovf <= 1'b1;
        else                  level    <= level + LW'(1);
      end else if (eret_take) begin
        ie_stack <= ie_stack >> 1;
        if (level != '0) level <= level - LW'(1);
      end else if (mtc0_take) begin
        case (c0_sel)
          SEL_STATUS: begin
            ie_stack <= wdata[NEST_DEPTH-1:0];
            im       <= wdata[8 +: NIRQ];
          end
          SEL_EPC: epc <= wdata;
          default: ;
        endcase
      end
      state <= (eret_take || (mtc0_take && c0_sel == SEL_STATUS)) ? ST_SHADOW : ST_RUN;
    end
  end

endmodule
